// File: rtl/sorted_list_reader.sv
// sorted_list_reader
//
// Drains the descending-sorted table produced by the pipelined sorting
// network and serialises it one entry per beat over a valid/ready stream.
// The block follows the network's fixed latency from the shared launch
// pulse, snapshots the table when it becomes valid, then emits entries
// from index 0 (largest key) upward.
//
// Optional feature macro: SORTED_LIST_READER_SKIP_ZERO_EN
//   Defined:   key 0 marks an empty slot; only the leading non-zero keys
//              are emitted, and an all-zero table produces no beats.
//   Undefined: every entry is emitted, zero keys included.
//
// Parameters:
//   N       entries per table (power of two, >= 2)
//   KEY_W   unsigned key width
//   DATA_W  payload width carried alongside each key
//   LAT     sorting network latency in cycles (>= 1)
//
// Ports:
//   clk          clock
//   rst          synchronous active-high reset
//   sort_start   launch pulse (also drives the network's input valid)
//   sorted_key   network output keys, entry i at [i*KEY_W +: KEY_W]
//   sorted_data  network output payloads, packed like sorted_key
//   busy         high whenever the block is not idle
//   out_valid    stream beat valid
//   out_ready    downstream accept
//   out_key      key of the current beat
//   out_data     payload of the current beat
//   out_idx      table index of the current beat
//   out_last     final beat of a table
//   done         one-cycle pulse after a table has been fully drained
//   overrun      sticky: a launch arrived while busy

module sorted_list_reader #(
    parameter int N      = 4,
    parameter int KEY_W  = 8,
    parameter int DATA_W = 16,
    parameter int LAT    = 3
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  sort_start,
    input  logic [N*KEY_W-1:0]    sorted_key,
    input  logic [N*DATA_W-1:0]   sorted_data,
    output logic                  busy,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [KEY_W-1:0]      out_key,
    output logic [DATA_W-1:0]     out_data,
    output logic [$clog2(N)-1:0]  out_idx,
    output logic                  out_last,
    output logic                  done,
    output logic                  overrun
);

    localparam int IDX_W = $clog2(N);
    localparam int CNT_W = (LAT > 1) ? $clog2(LAT) : 1;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        WAIT   = 2'd1,
        STREAM = 2'd2
    } state_t;

    state_t              state;
    state_t              state_next;
    logic [CNT_W-1:0]    cnt;
    logic [IDX_W-1:0]    rd_idx;
    logic [IDX_W-1:0]    last_idx;
    logic [IDX_W-1:0]    next_idx;
    logic [IDX_W:0]      beat_cnt;
    logic                capture;
    logic                handshake;
    logic                final_hs;

    logic [KEY_W-1:0]    snap_key  [N];
    logic [DATA_W-1:0]   snap_data [N];

    assign capture   = (state == WAIT) && (cnt == '0);
    assign handshake = out_valid && out_ready;
    assign final_hs  = handshake && out_last;
    assign next_idx  = rd_idx + IDX_W'(1);

    // Beat count M for the table currently presented by the network. It is
    // only used in the capture cycle, when sorted_key is guaranteed valid.
    // With zero skipping, the descending order means the empty slots form a
    // tail, so M is the length of the leading run of non-zero keys.
`ifdef SORTED_LIST_READER_SKIP_ZERO_EN
    logic run;
    always_comb begin
        beat_cnt = '0;
        run      = 1'b1;
        for (int i = 0; i < N; i++) begin
            if (run && (sorted_key[i*KEY_W +: KEY_W] != '0)) begin
                beat_cnt = beat_cnt + (IDX_W+1)'(1);
            end else begin
                run = 1'b0;
            end
        end
    end
`else
    always_comb begin
        beat_cnt = (IDX_W+1)'(N);
    end
`endif

    // Next-state logic. A launch is only accepted from IDLE; launches seen
    // in WAIT or STREAM never disturb the sequence and are flagged instead.
    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (sort_start) begin
                    state_next = WAIT;
                end
            end
            WAIT: begin
                if (cnt == '0) begin
                    state_next = (beat_cnt != '0) ? STREAM : IDLE;
                end
            end
            STREAM: begin
                if (final_hs) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Snapshot of the network output, taken at the end of the last latency
    // cycle. It needs no reset: its contents only matter once captured.
    always_ff @(posedge clk) begin
        if (capture) begin
            for (int i = 0; i < N; i++) begin
                snap_key[i]  <= sorted_key[i*KEY_W +: KEY_W];
                snap_data[i] <= sorted_data[i*DATA_W +: DATA_W];
            end
        end
    end

    // Registered datapath and stream outputs. The first beat is loaded
    // straight from the network inputs in the capture cycle so that it is
    // valid in the very next cycle; later beats come from the snapshot.
    // busy and out_valid are registered copies of the next state, which
    // keeps every output a flop and keeps out_ready off the valid path.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt       <= '0;
            rd_idx    <= '0;
            last_idx  <= '0;
            busy      <= 1'b0;
            out_valid <= 1'b0;
            out_key   <= '0;
            out_data  <= '0;
            out_idx   <= '0;
            out_last  <= 1'b0;
            done      <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            done      <= 1'b0;
            busy      <= (state_next != IDLE);
            out_valid <= (state_next == STREAM);

            if (sort_start && (state != IDLE)) begin
                overrun <= 1'b1;
            end

            case (state)
                IDLE: begin
                    if (sort_start) begin
                        cnt <= CNT_W'(LAT - 1);
                    end
                end
                WAIT: begin
                    if (cnt != '0) begin
                        cnt <= cnt - CNT_W'(1);
                    end else begin
                        last_idx <= IDX_W'(beat_cnt - (IDX_W+1)'(1));
                        rd_idx   <= '0;
                        if (beat_cnt != '0) begin
                            out_key  <= sorted_key[0 +: KEY_W];
                            out_data <= sorted_data[0 +: DATA_W];
                            out_idx  <= '0;
                            out_last <= (beat_cnt == (IDX_W+1)'(1));
                        end else begin
                            done <= 1'b1;
                        end
                    end
                end
                STREAM: begin
                    if (handshake) begin
                        if (out_last) begin
                            done     <= 1'b1;
                            out_last <= 1'b0;
                            out_key  <= '0;
                            out_data <= '0;
                            out_idx  <= '0;
                        end else begin
                            rd_idx   <= next_idx;
                            out_key  <= snap_key[next_idx];
                            out_data <= snap_data[next_idx];
                            out_idx  <= next_idx;
                            out_last <= (next_idx == last_idx);
                        end
                    end
                end
                default: begin
                    cnt <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sorted_list_reader.sv
// tb_sorted_list_reader
//
// Directed bench for sorted_list_reader. Each launched table pushes its
// expected beats (key, payload, index, last flag) onto a scoreboard queue;
// every cycle with out_valid high is compared against the queue head, and
// the head is popped on a handshake. Holding the head until the handshake
// also checks that a stalled beat stays stable. Cycle-accurate checks of
// busy, done and overrun are made around each launch.

module tb_sorted_list_reader;

    localparam int N      = 4;
    localparam int KEY_W  = 8;
    localparam int DATA_W = 16;
    localparam int LAT    = 3;

    typedef struct packed {
        logic [KEY_W-1:0]  key;
        logic [DATA_W-1:0] data;
        logic [1:0]        idx;
        logic              last;
    } beat_t;

    logic                 clk;
    logic                 rst;
    logic                 sort_start;
    logic [N*KEY_W-1:0]   sorted_key;
    logic [N*DATA_W-1:0]  sorted_data;
    logic                 busy;
    logic                 out_valid;
    logic                 out_ready;
    logic [KEY_W-1:0]     out_key;
    logic [DATA_W-1:0]    out_data;
    logic [1:0]           out_idx;
    logic                 out_last;
    logic                 done;
    logic                 overrun;

    logic [KEY_W-1:0]     tblKey  [N];
    logic [DATA_W-1:0]    tblData [N];
    beat_t                sbQueue [$];

    int passCount  = 0;
    int totalCount = 0;
    int hsCount    = 0;
    int doneCycle;

    sorted_list_reader #(
        .N      (N),
        .KEY_W  (KEY_W),
        .DATA_W (DATA_W),
        .LAT    (LAT)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .sort_start  (sort_start),
        .sorted_key  (sorted_key),
        .sorted_data (sorted_data),
        .busy        (busy),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_key     (out_key),
        .out_data    (out_data),
        .out_idx     (out_idx),
        .out_last    (out_last),
        .done        (done),
        .overrun     (overrun)
    );

    // Free-running clock.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Single comparison point: counts every check and reports failures.
    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        totalCount++;
        assert (observed === expected) passCount++;
        else $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
    endtask

    // Number of beats the table in tblKey should produce.
    function automatic int expBeats();
`ifdef SORTED_LIST_READER_SKIP_ZERO_EN
        int m;
        m = 0;
        while (m < N && tblKey[m] != '0) m++;
        return m;
`else
        return N;
`endif
    endfunction

    // Loads a table into the network model; payloads are tagged by index.
    task automatic loadTable(input logic [7:0] k0, input logic [7:0] k1,
                             input logic [7:0] k2, input logic [7:0] k3);
        tblKey[0] = k0;
        tblKey[1] = k1;
        tblKey[2] = k2;
        tblKey[3] = k3;
        for (int i = 0; i < N; i++) begin
            tblData[i] = {4'hD, 4'(i), tblKey[i]};
        end
    endtask

    // Pushes the expected beat sequence of the current table.
    task automatic pushTable();
        int m;
        beat_t b;
        m = expBeats();
        for (int i = 0; i < m; i++) begin
            b.key  = tblKey[i];
            b.data = tblData[i];
            b.idx  = 2'(i);
            b.last = (i == m - 1);
            sbQueue.push_back(b);
        end
    endtask

    // Advances to the middle of the next cycle, drives that cycle's inputs
    // and checks any beat on offer against the scoreboard head. The network
    // output is only meaningful in the cycle it is shown; otherwise noise.
    task automatic applyStimulus(input logic r, input logic start,
                                 input logic ready, input logic showTable);
        beat_t exp;
        @(negedge clk);
        rst        = r;
        sort_start = start;
        out_ready  = ready;
        if (showTable) begin
            for (int i = 0; i < N; i++) begin
                sorted_key[i*KEY_W +: KEY_W]    = tblKey[i];
                sorted_data[i*DATA_W +: DATA_W] = tblData[i];
            end
        end else begin
            sorted_key  = $urandom;
            sorted_data = {$urandom, $urandom};
        end
        if (out_valid) begin
            if (sbQueue.size() == 0) begin
                checkOutput("unexpected_beat", {31'd0, out_valid}, 32'd0);
            end else begin
                exp = sbQueue[0];
                checkOutput("beat_key",  {24'd0, out_key},  {24'd0, exp.key});
                checkOutput("beat_data", {16'd0, out_data}, {16'd0, exp.data});
                checkOutput("beat_idx",  {30'd0, out_idx},  {30'd0, exp.idx});
                checkOutput("beat_last", {31'd0, out_last}, {31'd0, exp.last});
                if (ready && !r) begin
                    void'(sbQueue.pop_front());
                    hsCount++;
                end
            end
        end
    endtask

    // Launches the current table in cycle 0 and runs until done is seen.
    // Optional extra launches model a misbehaving upstream. readyPat gives
    // out_ready for stream cycles LAT+1, LAT+2, ... repeating every 4.
    task automatic drainTable(input int extra1, input int extra2,
                              input logic [3:0] readyPat, output int dc);
        logic st;
        logic rdy;
        int   m;
        dc = -1;
        hsCount = 0;
        m = expBeats();
        pushTable();
        for (int c = 0; c < 64; c++) begin
            st  = (c == 0) || (c == extra1) || (c == extra2);
            rdy = (c > LAT) ? readyPat[(c - LAT - 1) % 4] : 1'b1;
            applyStimulus(1'b0, st, rdy, c == LAT);
            if (c == 0) begin
                checkOutput("busy_idle", {31'd0, busy}, 32'd0);
            end else if (c <= LAT) begin
                checkOutput("busy_wait",  {31'd0, busy},      32'd1);
                checkOutput("valid_wait", {31'd0, out_valid}, 32'd0);
            end else if (c == LAT + 1) begin
                checkOutput("first_valid", {31'd0, out_valid}, {31'd0, (m > 0)});
            end
            if (done) begin
                dc = c;
                break;
            end
        end
        if (dc < 0) checkOutput("done_timeout", 32'd0, 32'd1);
        checkOutput("handshakes", hsCount, m);
        checkOutput("queue_empty", sbQueue.size(), 32'd0);
        checkOutput("busy_at_done",  {31'd0, busy},      32'd0);
        checkOutput("valid_at_done", {31'd0, out_valid}, 32'd0);
    endtask

    initial begin
        rst         = 1'b1;
        sort_start  = 1'b0;
        out_ready   = 1'b0;
        sorted_key  = '0;
        sorted_data = '0;

        // Reset state.
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
        checkOutput("rst_busy",    {31'd0, busy},      32'd0);
        checkOutput("rst_valid",   {31'd0, out_valid}, 32'd0);
        checkOutput("rst_last",    {31'd0, out_last},  32'd0);
        checkOutput("rst_done",    {31'd0, done},      32'd0);
        checkOutput("rst_overrun", {31'd0, overrun},   32'd0);
        checkOutput("rst_key",     {24'd0, out_key},   32'd0);
        checkOutput("rst_data",    {16'd0, out_data},  32'd0);
        checkOutput("rst_idx",     {30'd0, out_idx},   32'd0);

        // Basic drain with out_ready held high: beats in cycles 4..7.
        loadTable(8'd40, 8'd30, 8'd20, 8'd10);
        drainTable(-1, -1, 4'b1111, doneCycle);
        checkOutput("basic_done_cycle", doneCycle, 32'd8);
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b0);
        checkOutput("done_pulse_len", {31'd0, done}, 32'd0);

        // Backpressure: ready pattern 1,0,0,1 repeating.
        drainTable(-1, -1, 4'b1001, doneCycle);
        checkOutput("bp_done_cycle", doneCycle, 32'd12);
        checkOutput("bp_no_overrun", {31'd0, overrun}, 32'd0);

        // Table with a zero tail.
        loadTable(8'd9, 8'd5, 8'd0, 8'd0);
        drainTable(-1, -1, 4'b1111, doneCycle);
        checkOutput("zero_tail_done_cycle", doneCycle, LAT + 1 + expBeats());

        // All-zero table.
        loadTable(8'd0, 8'd0, 8'd0, 8'd0);
        drainTable(-1, -1, 4'b1111, doneCycle);
        checkOutput("all_zero_done_cycle", doneCycle, LAT + 1 + expBeats());

        // Overrun: extra launches in WAIT (cycle 2) and in STREAM (cycle 5).
        loadTable(8'd40, 8'd30, 8'd20, 8'd10);
        drainTable(2, 5, 4'b1111, doneCycle);
        checkOutput("ovr_done_cycle", doneCycle, 32'd8);
        checkOutput("ovr_flag", {31'd0, overrun}, 32'd1);
        for (int i = 0; i < 4; i++) begin
            applyStimulus(1'b0, 1'b0, 1'b1, 1'b0);
            checkOutput("ovr_no_second_table", {31'd0, out_valid}, 32'd0);
            checkOutput("ovr_sticky", {31'd0, overrun}, 32'd1);
        end

        // Reset in the cycle after the second handshake.
        pushTable();
        applyStimulus(1'b0, 1'b1, 1'b1, 1'b0);
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b0);
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b0);
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b1);
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b0);
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b0);
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
        checkOutput("pre_rst_valid", {31'd0, out_valid}, 32'd1);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
        checkOutput("mid_rst_valid",   {31'd0, out_valid}, 32'd0);
        checkOutput("mid_rst_busy",    {31'd0, busy},      32'd0);
        checkOutput("mid_rst_overrun", {31'd0, overrun},   32'd0);
        checkOutput("mid_rst_done",    {31'd0, done},      32'd0);
        sbQueue.delete();

        // New table after the mid-stream reset.
        loadTable(8'd200, 8'd150, 8'd100, 8'd50);
        drainTable(-1, -1, 4'b1111, doneCycle);
        checkOutput("post_rst_done_cycle", doneCycle, 32'd8);

        $display("%0d/%0d checks passed", passCount, totalCount);
        $finish;
    end

endmodule
